// File: rtl/break_value_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : break_value_scheduler_pkg                                        |
// | Brief    : Shared WalkSAT pipeline constants, default sizes and the        |
// |            scheduler FSM state encoding.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package break_value_scheduler_pkg;

    // Default sizing of the break value scheduler / counter pair
    localparam int DEF_NUM_CLAUSES      = 20;
    localparam int DEF_NUM_CLAUSES_BITS = 5;
    localparam int DEF_NUM_CANDIDATES   = 3;
    localparam int DEF_CAND_BITS        = 2;

    // Width of the random byte and noise threshold used for the noisy pick
    localparam int RAND_BITS            = 8;

    // Scheduler pass states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EVAL = 3'd3,
        S_DONE = 3'd4
    } bvs_state_e;

endpackage
`default_nettype wire

// File: rtl/break_value_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : break_value_scheduler_if                                        |
// | Brief    : Mask-fetch handshake and break value counter bus between the    |
// |            scheduler (master) and its environment (slave).                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface break_value_scheduler_if
    import break_value_scheduler_pkg::*;
#(
    parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
    parameter int NUM_CLAUSES_BITS = DEF_NUM_CLAUSES_BITS,
    parameter int CAND_BITS        = DEF_CAND_BITS
) ();

    // Mask fetch handshake
    logic                        mask_req_o;
    logic [CAND_BITS-1:0]        cand_idx_o;
    logic                        mask_valid_i;
    logic [NUM_CLAUSES-1:0]      mask_bits_i;

    // Break value counter connection
    logic [NUM_CLAUSES-1:0]      bvc_status_o;
    logic [NUM_CLAUSES-1:0]      bvc_mask_o;
    logic [NUM_CLAUSES_BITS-1:0] bvc_break_value_i;

    modport master (
        output mask_req_o,
        output cand_idx_o,
        input  mask_valid_i,
        input  mask_bits_i,
        output bvc_status_o,
        output bvc_mask_o,
        input  bvc_break_value_i
    );

    modport slave (
        input  mask_req_o,
        input  cand_idx_o,
        output mask_valid_i,
        output mask_bits_i,
        input  bvc_status_o,
        input  bvc_mask_o,
        output bvc_break_value_i
    );

endinterface
`default_nettype wire

// File: rtl/break_value_scheduler_min_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bv_min_tracker                                                  |
// | Brief    : Running minimum break value and its candidate index, with       |
// |            lower-index-wins tie rule and zero (freebie) detect.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bv_min_tracker
    import break_value_scheduler_pkg::*;
#(
    parameter int NUM_CLAUSES_BITS = DEF_NUM_CLAUSES_BITS,
    parameter int CAND_BITS        = DEF_CAND_BITS
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    input  wire logic                        init_i,
    input  wire logic                        eval_i,
    input  wire logic [CAND_BITS-1:0]        idx_i,
    input  wire logic [NUM_CLAUSES_BITS-1:0] bv_i,
    output logic      [NUM_CLAUSES_BITS-1:0] min_o,
    output logic      [CAND_BITS-1:0]        argmin_o,
    output logic                             is_zero_o
);

    logic [NUM_CLAUSES_BITS-1:0] min_q;
    logic [CAND_BITS-1:0]        argmin_q;
    logic                        w_take;

    // Strictly-less keeps the earlier (lower) index on ties. Because the
    // argmin restarts at 0 alongside an all-ones min, a pass where every
    // candidate reports the maximum break value still ends on index 0.
    assign w_take    = eval_i && (bv_i < min_q);
    assign is_zero_o = (bv_i == '0);

    // Min/argmin registers: cleared at the start of each pass, updated in EVAL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q    <= '1;
            argmin_q <= '0;
        end else if (init_i) begin
            min_q    <= '1;
            argmin_q <= '0;
        end else if (w_take) begin
            min_q    <= bv_i;
            argmin_q <= idx_i;
        end
    end

    assign min_o    = min_q;
    assign argmin_o = argmin_q;

endmodule
`default_nettype wire

// File: rtl/break_value_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : break_value_scheduler                                           |
// | Brief    : Walks the candidate variables of an unsatisfied clause, fetches |
// |            each occurrence mask, feeds it to an external break value       |
// |            counter and selects the candidate to flip (greedy minimum with  |
// |            freebie early exit, or a noisy random pick).                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module break_value_scheduler
    import break_value_scheduler_pkg::*;
#(
    parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
    parameter int NUM_CLAUSES_BITS = DEF_NUM_CLAUSES_BITS,
    parameter int NUM_CANDIDATES   = DEF_NUM_CANDIDATES,
    parameter int CAND_BITS        = DEF_CAND_BITS
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    input  wire logic                        start_i,
    input  wire logic                        abort_i,
    input  wire logic [NUM_CLAUSES-1:0]      clause_status_i,
    input  wire logic [RAND_BITS-1:0]        rand_i,
    input  wire logic [RAND_BITS-1:0]        noise_thresh_i,
    input  wire logic [CAND_BITS-1:0]        rand_idx_i,
    break_value_scheduler_if.master          bvs_if,
    output logic                             busy_o,
    output logic                             done_o,
    output logic      [CAND_BITS-1:0]        sel_idx_o,
    output logic      [NUM_CLAUSES_BITS-1:0] sel_break_value_o
);

    localparam int LAST_CAND = NUM_CANDIDATES - 1;

    bvs_state_e                  state_q, state_d;
    logic [CAND_BITS-1:0]        cnt_q, cnt_d;
    logic [NUM_CLAUSES-1:0]      status_q;
    logic [NUM_CLAUSES-1:0]      mask_q;
    logic [RAND_BITS-1:0]        rand_q;
    logic [RAND_BITS-1:0]        thresh_q;
    logic [CAND_BITS-1:0]        rand_idx_q;
    logic                        done_q, done_d;
    logic [CAND_BITS-1:0]        sel_idx_q, sel_idx_d;
    logic [NUM_CLAUSES_BITS-1:0] sel_bv_q, sel_bv_d;

    logic                        w_init;
    logic                        w_eval;
    logic                        w_mask_load;
    logic                        w_mask_req;
    logic [NUM_CLAUSES_BITS-1:0] w_min_bv;
    logic [CAND_BITS-1:0]        w_min_idx;
    logic                        w_bv_zero;
    logic                        w_noise;
    logic [CAND_BITS-1:0]        w_noise_idx;

    bv_min_tracker #(
        .NUM_CLAUSES_BITS (NUM_CLAUSES_BITS),
        .CAND_BITS        (CAND_BITS)
    ) u_min_tracker (
        .clk       (clk),
        .reset     (reset),
        .init_i    (w_init),
        .eval_i    (w_eval),
        .idx_i     (cnt_q),
        .bv_i      (bvs_if.bvc_break_value_i),
        .min_o     (w_min_bv),
        .argmin_o  (w_min_idx),
        .is_zero_o (w_bv_zero)
    );

    // Noisy pick only when no freebie was found; an out-of-range random
    // index falls back to candidate 0.
    assign w_noise     = (w_min_bv != '0) && (rand_q < thresh_q);
    assign w_noise_idx = (int'(rand_idx_q) >= NUM_CANDIDATES) ? '0 : rand_idx_q;

    // Next-state and control decode for the scheduling pass
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        sel_idx_d   = sel_idx_q;
        sel_bv_d    = sel_bv_q;
        w_init      = 1'b0;
        w_eval      = 1'b0;
        w_mask_load = 1'b0;
        w_mask_req  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_init  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                w_mask_req = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bvs_if.mask_valid_i) begin
                    w_mask_load = 1'b1;
                    state_d     = S_EVAL;
                end
            end
            S_EVAL: begin
                w_eval = 1'b1;
                if (w_bv_zero || (int'(cnt_q) == LAST_CAND)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CAND_BITS'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                sel_idx_d = w_noise ? w_noise_idx : w_min_idx;
                sel_bv_d  = w_min_bv;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards the pass: nothing is loaded and the result holds
        if (abort_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            cnt_d       = cnt_q;
            done_d      = 1'b0;
            sel_idx_d   = sel_idx_q;
            sel_bv_d    = sel_bv_q;
            w_eval      = 1'b0;
            w_mask_load = 1'b0;
        end
    end

    // State, pass context latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            rand_q     <= '0;
            thresh_q   <= '0;
            rand_idx_q <= '0;
            done_q     <= 1'b0;
            sel_idx_q  <= '0;
            sel_bv_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            sel_idx_q <= sel_idx_d;
            sel_bv_q  <= sel_bv_d;
            if (w_init) begin
                status_q   <= clause_status_i;
                rand_q     <= rand_i;
                thresh_q   <= noise_thresh_i;
                rand_idx_q <= rand_idx_i;
            end
            if (w_mask_load) begin
                mask_q <= bvs_if.mask_bits_i;
            end
        end
    end

    assign bvs_if.mask_req_o   = w_mask_req;
    assign bvs_if.cand_idx_o   = cnt_q;
    assign bvs_if.bvc_status_o = status_q;
    assign bvs_if.bvc_mask_o   = mask_q;

    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = done_q;
    assign sel_idx_o         = sel_idx_q;
    assign sel_break_value_o = sel_bv_q;

endmodule
`default_nettype wire

// File: tb/tb_break_value_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_break_value_scheduler                                        |
// | Brief    : Self-checking bench: directed and random passes against a       |
// |            behavioural selection model, with a popcount break counter.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_break_value_scheduler;
    import break_value_scheduler_pkg::*;

    localparam int NC     = 20;
    localparam int NCB    = 5;
    localparam int NCAND  = 3;
    localparam int CB     = 2;
    localparam int BV_MAX = (1 << NCB) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_i;
    logic           abort_i;
    logic [NC-1:0]  clause_status_i;
    logic [7:0]     rand_i;
    logic [7:0]     noise_thresh_i;
    logic [CB-1:0]  rand_idx_i;
    logic           busy_o;
    logic           done_o;
    logic [CB-1:0]  sel_idx_o;
    logic [NCB-1:0] sel_break_value_o;
    logic           force_max;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    break_value_scheduler_if #(.NUM_CLAUSES(NC), .NUM_CLAUSES_BITS(NCB), .CAND_BITS(CB)) bus ();

    // Break value counter: clauses both critical (status=1) and touched by the mask
    assign bus.bvc_break_value_i = force_max ? NCB'(BV_MAX)
                                             : NCB'($countones(bus.bvc_status_o & bus.bvc_mask_o));

    break_value_scheduler #(
        .NUM_CLAUSES      (NC),
        .NUM_CLAUSES_BITS (NCB),
        .NUM_CANDIDATES   (NCAND),
        .CAND_BITS        (CB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .clause_status_i   (clause_status_i),
        .rand_i            (rand_i),
        .noise_thresh_i    (noise_thresh_i),
        .rand_idx_i        (rand_idx_i),
        .bvs_if            (bus),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .sel_idx_o         (sel_idx_o),
        .sel_break_value_o (sel_break_value_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One scheduling pass. abort_cand >= 0 aborts in the first WAIT cycle of
    // that candidate; reset_at >= 0 pulses reset that many cycles after start.
    // noisy adds spurious mask_valid in IDLE/EVAL, start while busy and abort with start.
    task automatic run_pass(
        input string         tag,
        input logic [NC-1:0] status,
        input logic [NC-1:0] m0, m1, m2,
        input logic [7:0]    rnd, thr,
        input logic [CB-1:0] ridx,
        input int            delay,
        input bit            noisy,
        input int            abort_cand,
        input int            reset_at
    );
        logic [NC-1:0]  masks [NCAND];
        int             bv [NCAND];
        int             n_eval, exp_min, exp_arg, exp_sel, exp_done;
        int             nreq, ndone, done_k, pend, due, abort_k, eval_k;
        logic [CB-1:0]  prev_sel;
        logic [NCB-1:0] prev_bv;
        bit             finished;

        masks[0] = m0;
        masks[1] = m1;
        masks[2] = m2;

        // Reference: evaluate in order, stop at the first zero, keep the
        // first smallest value, then apply the noise rule.
        for (int i = 0; i < NCAND; i++)
            bv[i] = force_max ? BV_MAX : $countones(status & masks[i]);
        n_eval = NCAND;
        for (int i = NCAND - 1; i >= 0; i--)
            if (bv[i] == 0) n_eval = i + 1;
        exp_min = bv[0];
        for (int i = 1; i < n_eval; i++)
            if (bv[i] < exp_min) exp_min = bv[i];
        exp_arg = 0;
        for (int i = n_eval - 1; i >= 0; i--)
            if (bv[i] == exp_min) exp_arg = i;
        if (exp_min > 0 && rnd < thr)
            exp_sel = (int'(ridx) >= NCAND) ? 0 : int'(ridx);
        else
            exp_sel = exp_arg;
        exp_done = n_eval * (3 + delay) + 1;

        prev_sel = sel_idx_o;
        prev_bv  = sel_break_value_o;
        nreq = 0; ndone = 0; done_k = -1; pend = -1; due = -1;
        abort_k = -1; eval_k = -1; finished = 1'b0;

        if (noisy) begin
            @(negedge clk);
            bus.mask_valid_i = 1'b1;
            bus.mask_bits_i  = NC'($urandom);
        end
        @(negedge clk);
        bus.mask_valid_i = 1'b0;
        start_i          = 1'b1;
        abort_i          = noisy;
        clause_status_i  = status;
        rand_i           = rnd;
        noise_thresh_i   = thr;
        rand_idx_i       = ridx;
        @(posedge clk);

        for (int k = 0; k < 200 && !finished; k++) begin
            @(negedge clk);
            start_i          = 1'b0;
            abort_i          = 1'b0;
            bus.mask_valid_i = 1'b0;
            clause_status_i  = NC'($urandom);
            rand_i           = 8'($urandom);
            noise_thresh_i   = 8'($urandom);
            rand_idx_i       = CB'($urandom);
            if (k == 0) check({tag, "/busy"}, busy_o, 1);
            if (done_o) begin
                ndone++;
                done_k = k;
            end
            if (bus.mask_req_o) begin
                check({tag, "/cand_idx"}, bus.cand_idx_o, nreq);
                pend = nreq;
                due  = k + 1 + delay;
                if (nreq == abort_cand) abort_k = k + 1;
                nreq++;
            end
            if (k == abort_k) begin
                abort_i = 1'b1;
                pend    = -1;
            end else if (pend >= 0 && k == due) begin
                bus.mask_valid_i = 1'b1;
                bus.mask_bits_i  = masks[pend];
                pend   = -1;
                eval_k = k + 1;
            end else if (noisy && k == eval_k) begin
                bus.mask_valid_i = 1'b1;
                bus.mask_bits_i  = NC'($urandom);
            end
            if (noisy && k == 2) start_i = 1'b1;
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                check({tag, "/rst_busy"}, busy_o, 0);
                check({tag, "/rst_sel_idx"}, sel_idx_o, 0);
                check({tag, "/rst_sel_bv"}, sel_break_value_o, 0);
                @(negedge clk);
                reset    = 1'b1;
                finished = 1'b1;
            end else if (k > 0 && !busy_o) begin
                finished = 1'b1;
            end
        end
        check({tag, "/terminated"}, finished, 1);

        if (reset_at >= 0) begin
            check({tag, "/rst_no_done"}, ndone, 0);
        end else if (abort_cand >= 0) begin
            check({tag, "/abort_no_done"}, ndone, 0);
            check({tag, "/abort_sel_idx"}, sel_idx_o, prev_sel);
            check({tag, "/abort_sel_bv"}, sel_break_value_o, prev_bv);
            check({tag, "/abort_idle"}, busy_o, 0);
        end else begin
            check({tag, "/done_count"}, ndone, 1);
            check({tag, "/done_cycle"}, done_k, exp_done);
            check({tag, "/sel_idx"}, sel_idx_o, exp_sel);
            check({tag, "/sel_bv"}, sel_break_value_o, exp_min);
            check({tag, "/mask_reqs"}, nreq, n_eval);
            @(negedge clk);
            check({tag, "/done_pulse"}, done_o, 0);
            check({tag, "/idle"}, busy_o, 0);
        end
    endtask

    initial begin
        reset            = 1'b0;
        start_i          = 1'b0;
        abort_i          = 1'b0;
        clause_status_i  = '0;
        rand_i           = '0;
        noise_thresh_i   = '0;
        rand_idx_i       = '0;
        force_max        = 1'b0;
        bus.mask_valid_i = 1'b0;
        bus.mask_bits_i  = '0;

        repeat (2) @(negedge clk);
        check("reset/busy", busy_o, 0);
        check("reset/done", done_o, 0);
        check("reset/sel_idx", sel_idx_o, 0);
        check("reset/sel_bv", sel_break_value_o, 0);
        check("reset/mask_req", bus.mask_req_o, 0);
        check("reset/bvc_status", bus.bvc_status_o, 0);
        check("reset/bvc_mask", bus.bvc_mask_o, 0);
        reset = 1'b1;
        @(negedge clk);

        // Break values {3,1,2}: greedy minimum
        run_pass("greedy", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd0, 8'd0, 2'd0, 0, 1'b0, -1, -1);
        // Break values {2,0,5}: freebie at candidate 1
        run_pass("freebie", 20'h0FFFF, 20'hF0300, 20'hF0000, 20'h0001F,
                 8'd0, 8'd0, 2'd0, 0, 1'b0, -1, -1);
        // Break values {4,4,4}: tie goes to the lowest index
        run_pass("tie", 20'h0FFFF, 20'h0000F, 20'h000F0, 20'h00F00,
                 8'd0, 8'd0, 2'd0, 0, 1'b0, -1, -1);
        // Noisy pick with an in-range random index
        run_pass("noise_idx2", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd10, 8'd200, 2'd2, 0, 1'b0, -1, -1);
        // Abort in WAIT of candidate 1, then reset mid-pass
        run_pass("abort", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd0, 8'd0, 2'd0, 0, 1'b0, 1, -1);
        run_pass("reset_mid", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd0, 8'd0, 2'd0, 0, 1'b0, -1, 4);
        // Noisy pick with an out-of-range random index
        run_pass("noise_idx3", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd10, 8'd200, 2'd3, 0, 1'b0, -1, -1);
        // Slow mask source with spurious handshakes and stray start/abort
        run_pass("slow_spurious", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd0, 8'd0, 2'd0, 5, 1'b1, -1, -1);
        // Every candidate reports the largest representable break value
        force_max = 1'b1;
        run_pass("all_max", 20'h0FFFF, 20'h00007, 20'h00010, 20'hF0300,
                 8'd0, 8'd0, 2'd0, 0, 1'b0, -1, -1);
        force_max = 1'b0;

        for (int p = 0; p < 10; p++) begin
            run_pass("random", NC'($urandom),
                     NC'($urandom & $urandom & $urandom),
                     NC'($urandom & $urandom & $urandom),
                     NC'($urandom & $urandom & $urandom),
                     8'($urandom), 8'($urandom), CB'($urandom),
                     int'($urandom_range(0, 3)), 1'b0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
